// File: rtl/mpy_sequencer.sv
// mpy_sequencer: control stage around the 18x18 shift-add multiplier.
// Takes an MPY request, drives zero-extended operands into the multiplier,
// waits for its done, then writes the 32-bit product to Rd (high word) and
// Rd+1 (low word) over a req/ack write port.
// Optional build macro: MPY_TIMEOUT_EN adds a WAIT watchdog that raises err.
module mpy_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int MPY_TIMEOUT   = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] src_val,
    input  logic [15:0] dst_val,
    input  logic [15:0] wp,
    input  logic [3:0]  rd,
    output logic [17:0] mul_a,
    output logic [17:0] mul_b,
    input  logic [35:0] mul_p,
    input  logic        mul_done,
    output logic        wr_req,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT,
        WR_HI,
        WR_LO,
        FIN
    } state_t;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    state_t        state_reg;
    state_t        state_next;
    logic [SW-1:0] settle_cnt_reg;
    logic [15:0]   wp_reg;
    logic [3:0]    rd_reg;
    logic [31:0]   prod_reg;
    logic          lo_armed_reg;   // WR_LO spends its first cycle with wr_req low
    logic [15:0]   base_addr;
    logic          timeout_hit;

    // The top four product bits are always zero for 16-bit operands.
    logic unused_p_hi;
    assign unused_p_hi = ^mul_p[35:32];

    // Byte address of Rd; arithmetic wraps modulo 2^16.
    assign base_addr = wp_reg + {11'b0, rd_reg, 1'b0};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == FIN);
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_reg == SW'(1)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mul_done) begin
                    state_next = WR_HI;
                end else if (timeout_hit) begin
                    state_next = FIN;
                end
            end
            WR_HI: begin
                wr_req  = 1'b1;
                wr_addr = base_addr;
                wr_data = prod_reg[31:16];
                if (wr_ack) begin
                    state_next = WR_LO;
                end
            end
            WR_LO: begin
                wr_req  = lo_armed_reg;
                wr_addr = base_addr + 16'd2;
                wr_data = prod_reg[15:0];
                if (lo_armed_reg && wr_ack) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latches, operand drive, settle counter and product capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a          <= '0;
            mul_b          <= '0;
            wp_reg         <= '0;
            rd_reg         <= '0;
            prod_reg       <= '0;
            settle_cnt_reg <= '0;
            lo_armed_reg   <= 1'b0;
        end else begin
            lo_armed_reg <= (state_reg == WR_LO) && (state_next == WR_LO);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mul_a          <= {2'b00, src_val};
                        mul_b          <= {2'b00, dst_val};
                        wp_reg         <= wp;
                        rd_reg         <= rd;
                        settle_cnt_reg <= SW'(SETTLE_CYCLES);
                    end
                end
                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg - SW'(1);
                end
                WAIT: begin
                    if (mul_done) begin
                        prod_reg <= mul_p[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MPY_TIMEOUT_EN
    localparam int TW = $clog2(MPY_TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_reg;
    logic          err_reg;

    // WAIT has lasted MPY_TIMEOUT cycles without the multiplier finishing.
    assign timeout_hit = (state_reg == WAIT) && !mul_done &&
                         (tmo_cnt_reg == TW'(MPY_TIMEOUT - 1));
    assign err = err_reg;

    // Cycles spent in WAIT for the current request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end else begin
            tmo_cnt_reg <= '0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            err_reg <= 1'b0;
        end else if (timeout_hit) begin
            err_reg <= 1'b1;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (MPY_TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_mpy_sequencer.sv
// tb_mpy_sequencer: randomized scoreboard bench for mpy_sequencer.
// A behavioural multiplier stub and a write-port responder surround the DUT;
// expected writes and done pulses are queued at request time and popped by
// a monitor. Define MPY_TIMEOUT_EN to also exercise the watchdog.
module tb_mpy_sequencer;

    localparam int SETTLE = 2;
    localparam int TMO    = 40;
    localparam int MUL_LAT = 17;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] src_val, dst_val, wp;
    logic [3:0]  rd;
    logic [17:0] mul_a, mul_b;
    logic [35:0] mul_p = '0;
    logic        mul_done = 1'b1;
    logic        wr_req;
    logic [15:0] wr_addr, wr_data;
    logic        wr_ack = 1'b0;
    logic        busy, done, err;

    mpy_sequencer #(.SETTLE_CYCLES(SETTLE), .MPY_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .src_val(src_val), .dst_val(dst_val), .wp(wp), .rd(rd),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [15:0] addr;
        logic [15:0] data;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ack_delay = 0;
    bit   stub_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic fail_now(input string name, input string msg);
        checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Multiplier stub: restarts whenever its operands change, presents
    // garbage on p while computing, and raises done MUL_LAT cycles later.
    logic [17:0] prev_a = '0, prev_b = '0;
    int          stub_cnt = 0;
    always @(posedge clk) begin
        if (mul_a != prev_a || mul_b != prev_b) begin
            prev_a   <= mul_a;
            prev_b   <= mul_b;
            stub_cnt <= MUL_LAT;
            mul_done <= 1'b0;
            mul_p    <= {4'h0, 32'($urandom)};
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            mul_done <= 1'b1;
            mul_p    <= 36'(prev_a) * 36'(prev_b);
        end
        if (stub_hold) mul_done <= 1'b0;
    end

    // Write responder and scoreboard monitor, sampling on the falling edge.
    initial begin : monitor
        int          wait_n;
        bit          pend;
        bit          just_acked;
        logic [15:0] hold_addr, hold_data;
        exp_t        e;
        wait_n = 0; pend = 0; just_acked = 0;
        hold_addr = '0; hold_data = '0;
        forever begin
            @(negedge clk);
            if (just_acked) chk("req_gap", 32'(wr_req), 0);
            just_acked = 0;
            if (wr_req) begin
                if (pend) begin
                    chk("addr_stable", 32'(wr_addr), 32'(hold_addr));
                    chk("data_stable", 32'(wr_data), 32'(hold_data));
                end
                if (wait_n >= ack_delay) begin
                    wr_ack = 1'b1;
                    pend = 0; wait_n = 0; just_acked = 1;
                    $display("write addr=%h data=%h", wr_addr, wr_data);
                    if (sb.size() == 0 || sb[0].is_done) begin
                        fail_now("unexpected_write", $sformatf("addr=%h data=%h", wr_addr, wr_data));
                    end else begin
                        e = sb.pop_front();
                        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                        chk("wr_data", 32'(wr_data), 32'(e.data));
                    end
                end else begin
                    wr_ack = 1'b0;
                    pend = 1; wait_n++;
                    hold_addr = wr_addr; hold_data = wr_data;
                end
            end else begin
                pend = 0; wait_n = 0;
                wr_ack = ($urandom_range(0, 3) == 0);   // stray acks must be ignored
            end
            if (done) begin
                $display("done err=%b latency=%0d", err, cyc - start_cyc);
                if (sb.size() == 0 || !sb[0].is_done) begin
                    fail_now("unexpected_done", $sformatf("queue=%0d", sb.size()));
                end else begin
                    e = sb.pop_front();
                    chk("done_err", 32'(err), 32'(e.err));
                    if (e.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                end
            end
        end
    end

    // Issue one request from IDLE and queue the responses it must produce.
    task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] w,
                         input logic [3:0] r, input int lat, input bit exp_err);
        exp_t        e;
        logic [31:0] prod;
        logic [15:0] base;
        @(negedge clk);
        src_val = s; dst_val = d; wp = w; rd = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        prod = 32'(s) * 32'(d);
        base = w + 16'(r) * 16'd2;
        $display("request src=%h dst=%h wp=%h rd=%0d", s, d, w, r);
        e.err = exp_err; e.lat = -1;
        if (!exp_err) begin
            e.is_done = 0; e.addr = base;         e.data = prod[31:16]; sb.push_back(e);
            e.is_done = 0; e.addr = base + 16'd2; e.data = prod[15:0];  sb.push_back(e);
        end
        e.is_done = 1; e.addr = '0; e.data = '0; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("completion_timeout", $sformatf("%0d responses missing", sb.size()));
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 0);
    endtask

    task automatic pulse_reset_check(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_wr_req"}, 32'(wr_req), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_done"},   32'(done), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);   // abandoned operation must stay silent
    endtask

    initial begin : stimulus
        logic [15:0] s, d, w;
        int          n;
        reset_n = 1'b0; start = 1'b0;
        src_val = '0; dst_val = '0; wp = '0; rd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (MUL_LAT + 3) @(negedge clk);

        // Directed products, zero-wait ack.
        ack_delay = 0;
        issue(16'h1234, 16'h5678, 16'h8300, 4'd3, -1, 1'b0); wait_idle(200);
        issue(16'hFFFF, 16'hFFFF, 16'h8300, 4'd0, -1, 1'b0); wait_idle(200);
        issue(16'h0000, 16'hBEEF, 16'h8300, 4'd5, -1, 1'b0); wait_idle(200);

        // Identical back-to-back: stale done is valid, WAIT lasts one cycle.
        issue(16'h00AB, 16'h0CD0, 16'h2000, 4'd7, -1, 1'b0); wait_idle(200);
        issue(16'h00AB, 16'h0CD0, 16'h2000, 4'd7, SETTLE + 4, 1'b0); wait_idle(200);
        issue(16'h00AB, 16'h0CD1, 16'h2000, 4'd7, -1, 1'b0); wait_idle(200);

        // Address wrap with slow ack, plus start pulses while busy.
        ack_delay = 3;
        issue(16'h4321, 16'h8765, 16'hFFE0, 4'd15, -1, 1'b0);
        repeat (3) begin
            repeat (4) @(negedge clk);
            src_val = 16'($urandom); dst_val = 16'($urandom); rd = 4'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(300);
        repeat (30) @(negedge clk);
        ack_delay = 0;

        // Reset during WAIT.
        issue(16'h1357, 16'h2468, 16'h3000, 4'd2, -1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        pulse_reset_check("rst_wait");
        issue(16'h0101, 16'h0202, 16'h3000, 4'd2, -1, 1'b0); wait_idle(200);

        // Reset during WR_HI with the request pending.
        ack_delay = 6;
        issue(16'h7777, 16'h0003, 16'h3100, 4'd4, -1, 1'b0);
        n = 0;
        while (!wr_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_req) fail_now("wr_req_seen", "no write request before reset");
        @(posedge clk); #1;
        pulse_reset_check("rst_wrhi");
        ack_delay = 0;
        issue(16'h0007, 16'h0009, 16'h3100, 4'd4, -1, 1'b0); wait_idle(200);

        // Randomized requests; roughly a quarter reuse the previous operands.
        s = 16'h0001; d = 16'h0001;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                s = 16'($urandom); d = 16'($urandom);
            end
            w = 16'($urandom);
            ack_delay = $urandom_range(0, 3);
            issue(s, d, w, 4'($urandom_range(0, 15)), -1, 1'b0);
            wait_idle(300);
        end
        ack_delay = 0;

`ifdef MPY_TIMEOUT_EN
        // Multiplier never finishes: err, done, no writes; err clears on start.
        stub_hold = 1'b1;
        issue(16'h1111, 16'h2222, 16'h8000, 4'd1, SETTLE + TMO, 1'b1);
        wait_idle(200);
        chk("err_sticky", 32'(err), 1);
        stub_hold = 1'b0;
        issue(16'h0003, 16'h0005, 16'h8000, 4'd1, -1, 1'b0);
        chk("err_clear", 32'(err), 0);
        wait_idle(200);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mpy_sequencer.md
Name: mpy_sequencer

Overview:
- Control stage directly upstream and downstream of the 18x18 shift-add multiplier in the TMS9900 core.
- Accepts an MPY request from the instruction decoder and drives the zero-extended operands into the multiplier.
- Waits for the multiplier's `done`, then writes the 32-bit product as two 16-bit words to workspace registers Rd and Rd+1 over a req/ack memory write port.

Parameters:
- SETTLE_CYCLES, 2: cycles waited after driving new operands before `mul_done` is trusted. Minimum 2.
- MPY_TIMEOUT, 40: maximum cycles in WAIT before `err` is raised. Used only with MPY_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request. Sampled only in IDLE.
- src_val  in  16  source operand (multiplicand).
- dst_val  in  16  current contents of Rd (multiplier).
- wp  in  16  workspace pointer, byte address.
- rd  in  4  destination register number.
- mul_a  out  18  to multiplier `a`.
- mul_b  out  18  to multiplier `b`.
- mul_p  in  36  from multiplier `p`.
- mul_done  in  1  from multiplier `done`.
- wr_req  out  1  memory write request.
- wr_addr  out  16  write byte address.
- wr_data  out  16  write data.
- wr_ack  in  1  write accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when both writes have completed.
- err  out  1  timeout flag. Tied to 0 without MPY_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs go to 0. State goes to IDLE. Internal latches are cleared.
  - Reset mid-operation abandons the operation with no further writes. An in-flight wr_req drops immediately.
  - The multiplier itself is not reset. It restarts only when mul_a/mul_b change.
- States: IDLE, SETTLE, WAIT, WR_HI, WR_LO, FIN.
- IDLE:
  - On start=1: latch src_val, dst_val, wp and rd.
  - Set mul_a={2'b00,src_val} and mul_b={2'b00,dst_val}, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - start in any other state is ignored. No queueing.
- SETTLE:
  - Decrement the counter. Go to WAIT when it reaches 0.
  - Purpose: the multiplier's stale `done` from the previous product must not be accepted.
  - If operands equal the previous request, the multiplier does not restart. Its `done` stays high and `p` is already valid, so WAIT exits on its first cycle. This is required behaviour, not an error.
- WAIT:
  - When mul_done=1, register P=mul_p[31:0] and go to WR_HI.
  - mul_p[35:32] is ignored; it is always 0 for 16-bit operands.
- WR_HI:
  - wr_req=1, wr_addr=wp+{rd,1'b0}, wr_data=P[31:16].
  - Address and data are held stable until a rising edge where wr_req=1 and wr_ack=1. Then go to WR_LO.
- WR_LO:
  - wr_req=1, wr_addr=wp+{rd,1'b0}+2, wr_data=P[15:0].
  - On ack, wr_req drops and the state goes to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - wr_req is deasserted for one cycle between the WR_HI and WR_LO writes.
  - wr_ack while wr_req=0 is ignored.
- Address arithmetic:
  - 16-bit, modulo 2^16, wraps silently.
  - rd=15 writes R15, then the word at wp+32.
- mul_a/mul_b hold their last values after completion, so the multiplier stays idle.
- Latency with SETTLE_CYCLES=2, zero-wait ack, fresh operands: start to done pulse = 2 + multiplier (~17) + 2 writes + 1 gap + 1.

Optional Feature:
- Macro: MPY_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT. If mul_done has not been seen after MPY_TIMEOUT cycles, set err=1, skip both writes, pulse done, return to IDLE.
  - err is sticky until the next accepted start or reset.
- When undefined: err is constant 0, there is no counter logic, and WAIT waits indefinitely.

Test Plan:
- Basic multiply:
  - Stimulus: src=0x1234, dst=0x5678, wp=0x8300, rd=3, ack immediate.
  - Required: writes 0x0626 to 0x8306, then 0x0060 to 0x8308; one done pulse; busy low afterwards.
- Maximum operands:
  - Stimulus: src=0xFFFF, dst=0xFFFF.
  - Required: writes 0xFFFE then 0x0001. Zero operand (src=0): writes 0x0000 and 0x0000.
- Identical back-to-back requests:
  - Stimulus: same request issued twice.
  - Required: the second completes with the same data, WAIT lasts 1 cycle, no hang. The next request with a different dst gives the correct product, not the stale one.
- Wrap-around and slow ack:
  - Stimulus: wp=0xFFE0, rd=15; wr_ack delayed 3 cycles per write.
  - Required: addresses 0xFFFE then 0x0000; addr/data stable while req is pending; start pulses during busy are ignored.
- Reset mid-operation:
  - Stimulus: reset_n low during WAIT, and again during WR_HI with req pending.
  - Required: wr_req/busy/done drop immediately; no writes after reset; the next start works normally.
- With MPY_TIMEOUT_EN:
  - Stimulus: multiplier stub holds mul_done=0.
  - Required: err=1 and done pulses MPY_TIMEOUT cycles after entering WAIT; no wr_req; err clears on the next start.
